// File: rtl/bus_uart_tx.sv
// ---------------------------------------------------------------------------
// bus_uart_tx
//   Memory-mapped UART transmitter: a small CPU register window feeding a
//   circular byte FIFO, drained by a start/8-data/stop serial framer.
//
//   Optional feature macro: BUS_UART_TX_PARITY_EN
//     defined   -> an even-parity bit is inserted between data and stop
//                  (11-bit frame)
//     undefined -> 10-bit frame (start, 8 data LSB first, stop)
//
//   Register window (addr_i[31:4] must match BASE_ADDR[31:4]):
//     idx 0 DATA     write (wstrb_i[0]) pushes wvalue_i[7:0]; reads 0
//     idx 1 STATUS   [0] full [1] empty [2] frame active [3] overflow (sticky)
//                    [12:8] FIFO count; write wvalue_i[3]=1 clears overflow
//     idx 2 DIVISOR  reads CLK_DIV[15:0]; read-only
//     idx 3 reserved reads 0
//
//   Ports:
//     clk_i     system clock
//     rst_i     asynchronous active-high reset
//     enable_i  bus access valid this cycle
//     wstrb_i   byte write strobes, 0 = read
//     addr_i    byte address
//     wvalue_i  write data
//     rvalue_o  read data, one cycle after the access, 0 otherwise
//     tx_o      serial line, idle high
//     busy_o    FIFO non-empty or a frame in progress
// ---------------------------------------------------------------------------
module bus_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wvalue_i,
    output logic [31:0] rvalue_o,
    output logic        tx_o,
    output logic        busy_o
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]       DIV16     = 16'(CLK_DIV);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
`ifdef BUS_UART_TX_PARITY_EN
        , ST_PARITY
`endif
    } state_t;

    // ---------------- bus decode ----------------
    logic       sel;
    logic [1:0] idx;
    logic       is_read;
    logic       push_req;
    logic       clr_ovf;

    assign sel      = enable_i && (addr_i[31:4] == BASE_ADDR[31:4]);
    assign idx      = addr_i[3:2];
    assign is_read  = sel && (wstrb_i == 4'b0000);
    assign push_req = sel && (idx == 2'd0) && wstrb_i[0];
    assign clr_ovf  = sel && (idx == 2'd1) && wstrb_i[0] && wvalue_i[3];

    // Bits that never influence behaviour.
    logic unused_bits;
    assign unused_bits = ^{addr_i[1:0], wvalue_i[31:8]};

    // ---------------- FIFO ----------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             ovf_reg;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push_ok;

    state_t           state_reg;

    assign full  = (count_reg == CNT_FULL);
    assign empty = (count_reg == '0);
    assign pop   = (state_reg == ST_IDLE) && !empty;
    // A pop in the same cycle frees a slot, so a push to a full FIFO is legal then.
    assign push_ok = push_req && (!full || pop);

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wvalue_i[7:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // A fresh overflow event takes priority over a simultaneous clear.
            if (push_req && !push_ok) begin
                ovf_reg <= 1'b1;
            end else if (clr_ovf) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    // ---------------- read path ----------------
    logic [31:0] rd_data;
    logic [31:0] rvalue_reg;

    always_comb begin
        rd_data = '0;
        if (is_read) begin
            case (idx)
                2'd1:    rd_data = {19'b0, 5'(count_reg), 4'b0,
                                    ovf_reg, (state_reg != ST_IDLE), empty, full};
                2'd2:    rd_data = {16'b0, DIV16};
                default: rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalue_reg <= '0;
        end else begin
            rvalue_reg <= rd_data;
        end
    end

    assign rvalue_o = rvalue_reg;

    // ---------------- transmit FSM ----------------
    // tx_reg always carries the line level of the state being entered, so the
    // serial output is a clean register.
    logic [BAUD_W-1:0] baud_reg;
    logic [2:0]        bit_cnt_reg;
    logic [7:0]        shift_reg;
    logic              tx_reg;
    logic              baud_done;
`ifdef BUS_UART_TX_PARITY_EN
    logic              par_reg;
`endif

    assign baud_done = (baud_reg == BAUD_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            tx_reg      <= 1'b1;
            baud_reg    <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
`ifdef BUS_UART_TX_PARITY_EN
            par_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    baud_reg <= '0;
                    tx_reg   <= 1'b1;
                    if (!empty) begin
                        shift_reg <= mem[rd_ptr_reg];
`ifdef BUS_UART_TX_PARITY_EN
                        par_reg   <= ^mem[rd_ptr_reg];
`endif
                        state_reg <= ST_START;
                        tx_reg    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        baud_reg    <= '0;
                        bit_cnt_reg <= '0;
                        state_reg   <= ST_DATA;
                        tx_reg      <= shift_reg[0];
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_reg <= '0;
                        if (bit_cnt_reg == 3'd7) begin
`ifdef BUS_UART_TX_PARITY_EN
                            state_reg <= ST_PARITY;
                            tx_reg    <= par_reg;
`else
                            state_reg <= ST_STOP;
                            tx_reg    <= 1'b1;
`endif
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            shift_reg   <= shift_reg >> 1;
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
`ifdef BUS_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_done) begin
                        baud_reg  <= '0;
                        state_reg <= ST_STOP;
                        tx_reg    <= 1'b1;
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_done) begin
                        baud_reg  <= '0;
                        state_reg <= ST_IDLE;
                        tx_reg    <= 1'b1;
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    tx_reg    <= 1'b1;
                    baud_reg  <= '0;
                end
            endcase
        end
    end

    assign tx_o   = tx_reg;
    assign busy_o = (state_reg != ST_IDLE) || !empty;

endmodule

// File: tb/tb_bus_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_bus_uart_tx
//   Directed stimulus with hand-computed expectations. Read responses and
//   transmitted bytes are queued when issued; two monitors (read port and
//   serial line decoder) pop and compare independently of the stimulus.
// ---------------------------------------------------------------------------
module tb_bus_uart_tx;

    localparam logic [31:0] BASE     = 32'h1000_0000;
    localparam int          CLK_DIV  = 4;
    localparam int          DEPTH    = 8;
`ifdef BUS_UART_TX_PARITY_EN
    localparam int          NBITS    = 11;
`else
    localparam int          NBITS    = 10;
`endif
    localparam int          FRAME_CYC = NBITS * CLK_DIV;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic [3:0]  wstrb_i = 4'h0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wvalue_i = 32'h0;
    logic [31:0] rvalue_o;
    logic        tx_o;
    logic        busy_o;

    bus_uart_tx #(
        .BASE_ADDR (BASE),
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .enable_i(enable_i),
        .wstrb_i (wstrb_i),
        .addr_i  (addr_i),
        .wvalue_i(wvalue_i),
        .rvalue_o(rvalue_o),
        .tx_o    (tx_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int passed = 0;

    logic [31:0] exp_rd[$];
    logic [7:0]  exp_tx[$];

    logic rd_issue = 1'b0;
    logic rd_issue_d;

    int  last_gap = 0;
    bit  collecting = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        enable_i = 1'b1; addr_i = a; wvalue_i = d; wstrb_i = s;
        @(posedge clk_i); #1;
        enable_i = 1'b0; addr_i = 32'h0; wvalue_i = 32'h0; wstrb_i = 4'h0;
        $display("write addr=0x%08h data=0x%08h strb=%b", a, d, s);
    endtask

    task automatic push_byte(input logic [7:0] b, input bit expect_sent);
        if (expect_sent) exp_tx.push_back(b);
        bus_write(BASE, {24'h0, b}, 4'h1);
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] expv);
        enable_i = 1'b1; addr_i = a; wstrb_i = 4'h0; rd_issue = 1'b1;
        exp_rd.push_back(expv);
        @(posedge clk_i); #1;
        enable_i = 1'b0; addr_i = 32'h0; rd_issue = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk_i); #1;
            if (!busy_o && !collecting) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, maxc);
        end
    endtask

    // ---------------- read monitor ----------------
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rd_issue_d <= 1'b0;
        else       rd_issue_d <= rd_issue;
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (rd_issue_d) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    $display("FAIL read_scoreboard: got 0x%08h required no pending read", rvalue_o);
                end else begin
                    logic [31:0] e;
                    e = exp_rd.pop_front();
                    $display("read data=0x%08h expected=0x%08h", rvalue_o, e);
                    check("read_data", rvalue_o, e);
                end
            end else begin
                check("rvalue_idle_zero", rvalue_o, 32'h0);
            end
        end
    end

    // ---------------- serial line monitor ----------------
    logic smp [FRAME_CYC];
    int   sidx = 0;
    int   idle_cnt = 0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            collecting = 1'b0;
            idle_cnt   = 0;
            sidx       = 0;
        end else if (!collecting) begin
            if (tx_o == 1'b0) begin
                collecting = 1'b1;
                last_gap   = idle_cnt;
                smp[0]     = tx_o;
                sidx       = 1;
            end else begin
                idle_cnt++;
            end
        end else begin
            smp[sidx] = tx_o;
            sidx++;
            if (sidx == FRAME_CYC) begin
                logic [7:0] got;
                bit         shape_ok;
                shape_ok = 1'b1;
                for (int b = 0; b < NBITS; b++) begin
                    for (int k = 1; k < CLK_DIV; k++) begin
                        if (smp[b*CLK_DIV + k] !== smp[b*CLK_DIV]) shape_ok = 1'b0;
                    end
                end
                for (int b = 0; b < 8; b++) got[b] = smp[(b+1)*CLK_DIV];
                if (smp[0] !== 1'b0) shape_ok = 1'b0;
                if (smp[(NBITS-1)*CLK_DIV] !== 1'b1) shape_ok = 1'b0;
`ifdef BUS_UART_TX_PARITY_EN
                if (smp[9*CLK_DIV] !== ^got) shape_ok = 1'b0;
`endif
                if (exp_tx.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_frame: got byte 0x%02h required no frame", got);
                end else begin
                    logic [7:0] e;
                    e = exp_tx.pop_front();
                    $display("frame byte=0x%02h expected=0x%02h shape_ok=%0d gap=%0d", got, e, shape_ok, last_gap);
                    check("frame_data", {24'h0, got}, {24'h0, e});
                    check("frame_shape", {31'h0, shape_ok}, 32'h1);
                end
                collecting = 1'b0;
                idle_cnt   = 0;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_tx", {31'h0, tx_o}, 32'h1);
        check("reset_busy", {31'h0, busy_o}, 32'h0);
        check("reset_rvalue", rvalue_o, 32'h0);
        rst_i = 1'b0;
        wait_cycles(2);

        // Register map after reset.
        bus_read(BASE + 32'h4, 32'h0000_0002);   // empty
        bus_read(BASE + 32'h8, 32'd4);           // divisor
        bus_read(BASE + 32'hC, 32'h0);           // reserved
        bus_read(BASE + 32'h0, 32'h0);           // DATA reads 0
        bus_read(BASE + 32'h5, 32'h0000_0002);   // low address bits ignored
        bus_read(32'h2000_0004, 32'h0);          // outside window

        // Single frame 0xA5 and busy duration.
        push_byte(8'hA5, 1'b1);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_i); #1;
            n++;
            if (!busy_o) break;
        end
        check("busy_cycles", n, FRAME_CYC + 1);
        wait_cycles(2);

        // Back-to-back frames with a single idle cycle.
        push_byte(8'h55, 1'b1);
        push_byte(8'h0F, 1'b1);
        wait_idle("idle_b2b", 300);
        check("b2b_gap", last_gap, 32'd1);

        // Overflow: one frame in flight, then 9 pushes into an 8-deep FIFO.
        push_byte(8'h11, 1'b1);
        wait_cycles(3);
        for (int i = 1; i <= 8; i++) push_byte(8'h20 + 8'(i), 1'b1);
        push_byte(8'h29, 1'b0);
        bus_read(BASE + 32'h4, 32'h0000_080D);   // count 8, ovf, active, full
        wait_cycles(50);
        bus_read(BASE + 32'h4, 32'h0000_070C);   // count 7 after one pop
        wait_idle("idle_ovf", 1000);
        bus_read(BASE + 32'h4, 32'h0000_000A);   // empty, ovf sticky

        bus_write(BASE + 32'h4, 32'h8, 4'b0010);  // strobe bit 0 low: no clear
        bus_read(BASE + 32'h4, 32'h0000_000A);
        bus_write(BASE + 32'h4, 32'h8, 4'b0001);  // clear overflow
        bus_read(BASE + 32'h4, 32'h0000_0002);
        bus_write(BASE, 32'h77, 4'b1110);         // DATA without strobe 0: no push
        bus_write(BASE + 32'hC, 32'hFF, 4'hF);    // reserved: ignored
        bus_write(32'h2000_0000, 32'h66, 4'h1);   // outside window: no push
        bus_read(BASE + 32'h4, 32'h0000_0002);
        bus_read(BASE + 32'h8, 32'd4);
        bus_read(BASE + 32'hC, 32'h0);
        wait_cycles(5);

        // Parity-sensitive byte (parity bit 1 when enabled).
        push_byte(8'h07, 1'b1);
        wait_idle("idle_07", 200);

        // Reset during data bit 3 of 0xA5.
        push_byte(8'hA5, 1'b1);
        wait_cycles(18);
        check("pre_reset_bit3", {31'h0, tx_o}, 32'h0);
        rst_i = 1'b1;
        exp_tx.delete();
        #1;
        check("reset_mid_tx", {31'h0, tx_o}, 32'h1);
        check("reset_mid_busy", {31'h0, busy_o}, 32'h0);
        wait_cycles(2);
        rst_i = 1'b0;
        wait_cycles(2);
        bus_read(BASE + 32'h4, 32'h0000_0002);
        wait_cycles(5);
        check("post_reset_idle_tx", {31'h0, tx_o}, 32'h1);

        // First push after reset release.
        push_byte(8'h3C, 1'b1);
        wait_idle("idle_3c", 200);
        wait_cycles(3);

        check("tx_queue_drained", exp_tx.size(), 32'd0);
        check("rd_queue_drained", exp_rd.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
